// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

   // funct3[1:0] encoding of the divide/remainder group
   typedef enum logic [1:0] {
      DIV_S = 2'b00,
      DIV_U = 2'b01,
      REM_S = 2'b10,
      REM_U = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_t;

   // Major opcode shared by the M-extension instructions
   localparam logic [6:0] OPC_MULDIV = 7'b0110011;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift remainder:quotient left by one,
// try to subtract the divisor, and record success as the new quotient LSB.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] rem_shift;
   logic           ge;

   // Trial subtraction; the result always fits in WIDTH bits because the
   // incoming remainder is below the divisor, so modular WIDTH-bit math is exact.
   always_comb begin
      rem_shift = {rem_in, quo_in[WIDTH-1]};
      ge        = rem_shift >= {1'b0, divisor};
      rem_out   = rem_shift[WIDTH-1:0] - (ge ? divisor : '0);
      quo_out   = {quo_in[WIDTH-2:0], ge};
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit for the execute stage.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero and signed overflow finish
// straight from IDLE instead of running the full iteration loop.
// Handshake: div_stall is high while the op is accepted or iterating; the
// result is valid only in the single cycle div_done is high, which is also the
// cycle the pipeline advances and captures it.
module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_en,
   input  logic [1:0]       div_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] result,
   output logic             div_stall,
   output logic             div_done
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_t       state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
   logic             neg_quo_q, neg_rem_q;
   div_op_t          op_q;

   div_op_t          op_in;
   logic             is_signed, b_zero, ovf, fast_go;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH-1:0] step_rem, step_quo;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Operand decode: magnitudes for signed ops and the two special cases
   always_comb begin
      op_in     = div_op_t'(div_op);
      is_signed = (op_in == DIV_S) || (op_in == REM_S);
      abs_a     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
      abs_b     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
      b_zero    = (src_b == '0);
      ovf       = is_signed && (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);
   end

`ifdef DIV_FAST_PATH_EN
   assign fast_go = b_zero || ovf;
`else
   assign fast_go = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (dvsr_q),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic and stall/done strobes
   always_comb begin
      state_next = state;
      div_stall  = 1'b0;
      div_done   = 1'b0;
      case (state)
         IDLE: begin
            if (div_en) begin
               div_stall  = 1'b1;
               state_next = fast_go ? DONE : CALC;
            end
         end
         CALC: begin
            div_stall = 1'b1;
            if (cnt == CNT_W'(1)) state_next = DONE;
         end
         DONE: begin
            div_done   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture in IDLE, one restoring iteration per CALC cycle.
   // The fast path preloads the values the loop would have converged to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         op_q      <= DIV_S;
      end else begin
         case (state)
            IDLE: begin
               if (div_en) begin
                  op_q      <= op_in;
                  dvsr_q    <= abs_b;
                  neg_quo_q <= (op_in == DIV_S) && (src_a[WIDTH-1] ^ src_b[WIDTH-1]) && !b_zero;
                  neg_rem_q <= (op_in == REM_S) && src_a[WIDTH-1];
                  if (fast_go) begin
                     cnt   <= '0;
                     quo_q <= b_zero ? '1 : abs_a;
                     rem_q <= b_zero ? abs_a : '0;
                  end else begin
                     cnt   <= CNT_W'(WIDTH);
                     quo_q <= abs_a;
                     rem_q <= '0;
                  end
               end
            end
            CALC: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               cnt   <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Sign fixup and result select, driven only during DONE
   always_comb begin
      quo_fix = neg_quo_q ? -quo_q : quo_q;
      rem_fix = neg_rem_q ? -rem_q : rem_q;
      result  = '0;
      if (state == DONE)
         result = ((op_q == REM_S) || (op_q == REM_U)) ? rem_fix : quo_fix;
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: hand-computed results, latency and
// stall-length checks, back-to-back ops and asynchronous reset mid-iteration.
module tb_div_unit;
   import div_pkg::*;

   localparam int W = 32;

`ifdef DIV_FAST_PATH_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         div_en;
   logic [1:0]   div_op;
   logic [W-1:0] src_a, src_b;
   logic [W-1:0] result;
   logic         div_stall, div_done;

   int n_vec = 0;
   int n_err = 0;

   div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .div_en    (div_en),
      .div_op    (div_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .result    (result),
      .div_stall (div_stall),
      .div_done  (div_done)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Apply one op starting at the next negedge (cycle T) and follow it to div_done.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit special);
      int n, stalls, exp_lat;
      bit seen;
      @(negedge clk);
      div_en = 1'b1; div_op = op; src_a = a; src_b = b;
      n = 0; stalls = 0; seen = 1'b0;
      while (!seen && n < 100) begin
         #1;
         if (div_done) begin
            seen = 1'b1;
            check({tag, " result"}, result, exp);
            check({tag, " stall_at_done"}, 32'(div_stall), 32'd0);
         end else begin
            if (div_stall) stalls++;
            n++;
            @(negedge clk);
         end
      end
      exp_lat = (FAST && special) ? 1 : W + 1;
      if (!seen) check({tag, " result_timeout"}, result, exp);
      check({tag, " latency"}, n, exp_lat);
      check({tag, " stall_cycles"}, stalls, exp_lat);
   endtask

   initial begin
      int dones;
      rst = 1'b1; div_en = 1'b0; div_op = 2'b00; src_a = '0; src_b = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset result", result, 32'd0);
      check("reset done", 32'(div_done), 32'd0);
      check("reset stall", 32'(div_stall), 32'd0);
      check("reset state", 32'(dut.state), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;

      run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
      run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0);
      run_op("div -7/2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      run_op("rem -7/2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
      run_op("rem 7/-2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
      run_op("div 7/-2",   2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
      run_op("divu 5/0",   2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
      run_op("remu 5/0",   2'b11, 32'd5, 32'd0, 32'd5, 1'b1);
      run_op("div -5/0",   2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1);
      run_op("rem -5/0",   2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1);
      run_op("div ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run_op("rem ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
      run_op("divu big",   2'b01, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 1'b0);

      // back-to-back: second op is applied in the cycle right after DONE
      run_op("b2b divu 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 1'b0);
      run_op("b2b remu 9/4", 2'b11, 32'd9, 32'd4, 32'd1, 1'b0);
      @(negedge clk);
      div_en = 1'b0;
      #1;
      check("idle after b2b done", 32'(div_done), 32'd0);
      check("idle after b2b stall", 32'(div_stall), 32'd0);

      // asynchronous reset in the middle of an iteration
      @(negedge clk);
      div_en = 1'b1; div_op = 2'b01; src_a = 32'd1000; src_b = 32'd3;
      repeat (10) @(negedge clk);
      #1;
      check("pre-rst stall", 32'(div_stall), 32'd1);
      check("pre-rst state", 32'(dut.state), 32'(CALC));
      #1;
      rst = 1'b1; div_en = 1'b0;
      #1;
      check("rst stall", 32'(div_stall), 32'd0);
      check("rst state", 32'(dut.state), 32'(IDLE));
      check("rst done", 32'(div_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (div_done) dones++;
      end
      check("no done after rst", dones, 0);
      run_op("divu 8/2 after rst", 2'b01, 32'd8, 32'd2, 32'd4, 1'b0);
      @(negedge clk);
      div_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
